// File: rtl/instr_decode_pkg.sv
// instr_decode_pkg: shared formats, RV32I opcode constants and decoded-instruction struct.
package instr_decode_pkg;
  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd6
  } fmt_e;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        illegal;
    logic [31:0] pc;
  } dec_t;
  function automatic fmt_e op_fmt(input logic [6:0] op);
    return op == OP_REG ? FMT_R :
           (op == OP_IMM || op == OP_LOAD || op == OP_JALR) ? FMT_I :
           op == OP_STORE ? FMT_S :
           op == OP_BRANCH ? FMT_B :
           (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
           op == OP_JAL ? FMT_J : FMT_ILLEGAL;
  endfunction
endpackage

// File: rtl/instr_decode_fields.sv
// decode_fields: combinational RV32I field and immediate extraction.
module decode_fields
  import instr_decode_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output dec_t        dec
);
  fmt_e        fmt;
  logic [31:0] imm;
  always_comb begin
    fmt = op_fmt(instr[6:0]);
    imm = fmt == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
          fmt == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          fmt == FMT_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          fmt == FMT_U ? {instr[31:12], 12'b0} :
          fmt == FMT_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          32'd0;
  end
  assign dec = '{
    opcode:  instr[6:0],
    funct3:  instr[14:12],
    funct7:  instr[31:25],
    rs1:     instr[19:15],
    rs2:     instr[24:20],
    rd:      instr[11:7],
    imm:     imm,
    fmt:     fmt,
    illegal: fmt == FMT_ILLEGAL,
    pc:      pc
  };
endmodule

// File: rtl/instr_decode.sv
// instr_decode: RV32I decode stage with output + skid buffer and ready/valid handshakes.
// Optional DECODE_STATS_EN adds stat_decoded / stat_illegal transfer counters.
module instr_decode
  import instr_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic [2:0]  out_fmt,
  output logic        out_illegal,
  output logic [31:0] out_pc
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0] stat_decoded,
  output logic [31:0] stat_illegal
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e state, state_n;
  dec_t   dec, out_q, out_n, skid_q, skid_n;
  logic   ready_q, acc, xfer;
  decode_fields u_fields (.instr(in_instr), .pc(in_pc), .dec(dec));
  assign acc       = in_valid && ready_q;
  assign out_valid = state != EMPTY;
  assign xfer      = out_valid && out_ready;
  assign in_ready  = ready_q;
  always_comb begin
    state_n = state;
    out_n   = out_q;
    skid_n  = skid_q;
    if (flush)
      state_n = EMPTY;
    else
      case (state)
        EMPTY: if (acc) begin
          state_n = ONE;
          out_n   = dec;
        end
        ONE: if (acc && xfer)
          out_n = dec;
        else if (acc) begin
          state_n = FULL;
          skid_n  = dec;
        end else if (xfer)
          state_n = EMPTY;
        FULL: if (xfer) begin
          state_n = ONE;
          out_n   = skid_q;
        end
        default: state_n = EMPTY;
      endcase
  end
  // in_ready is registered from the next state so out_ready never reaches it combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_n;
      ready_q <= state_n != FULL;
      out_q   <= out_n;
      skid_q  <= skid_n;
    end
`ifdef DECODE_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (xfer && !flush) begin
      stat_decoded <= stat_decoded + 32'd1;
      stat_illegal <= stat_illegal + {31'd0, out_q.illegal};
    end
`endif
  assign out_opcode  = out_q.opcode;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_pc      = out_q.pc;
endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream fetch handshake.
REQ-004 SHALL have ports in_instr (input, 32): RV32I instruction word; in_pc (input, 32): its address.
REQ-005 SHALL have port flush, input, 1: discard all held instructions.
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream execute handshake.
REQ-007 SHALL have outputs out_opcode 7, out_funct3 3, out_funct7 7, out_rs1 5, out_rs2 5, out_rd 5: raw instruction fields.
REQ-008 SHALL have output out_imm, 32: sign-extended immediate per format.
REQ-009 SHALL have outputs out_fmt 3 (format code: R, I, S, B, U, J, ILLEGAL), out_illegal 1, and out_pc 32.

Function
REQ-010 SHALL transfer input when in_valid && in_ready; SHALL transfer output when out_valid && out_ready.
REQ-011 SHALL present a decoded instruction on out_* exactly one cycle after acceptance when the output stage is empty.
REQ-012 SHALL buffer up to two instructions (output register plus skid register); states EMPTY, ONE, FULL.
REQ-013 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without output transfer; ONE->EMPTY on output transfer without accept; FULL->ONE on output transfer (skid moves to output); otherwise hold.
REQ-014 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, registered so it has no combinational path from out_ready.
REQ-015 Accept and output transfer in the same cycle in ONE SHALL stay ONE with the new instruction on out_*.
REQ-016 Order SHALL be preserved; no instruction dropped or duplicated under any out_ready pattern.
REQ-017 out_* SHALL hold stable while out_valid && !out_ready.
REQ-018 Opcode map: 0110011 R; 0010011, 0000011, 1100111 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J; anything else ILLEGAL.
REQ-019 Immediates: I = sext(instr[31:20]) including shifts; S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); U = {instr[31:12],12'b0}; J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); R and ILLEGAL = 0.
REQ-020 ILLEGAL SHALL set out_illegal=1; raw fields still passed through.
REQ-021 flush SHALL clear both entries to EMPTY next cycle; an in_valid in the flush cycle SHALL be discarded; flush wins over accept.

Reset
REQ-022 On rst: state EMPTY, out_valid=0, in_ready=1, out_illegal=0, all out_* fields, out_imm, out_pc = 0, out_fmt = R code.
REQ-023 Reset mid-operation SHALL discard all held instructions immediately; first accept after release SHALL behave as from EMPTY.

Configuration
REQ-024 Macro DECODE_STATS_EN SHALL, when defined, add outputs stat_decoded (32) and stat_illegal (32): counts of output transfers and of those with out_illegal=1, wrapping at 2^32, cleared by rst, not by flush.
REQ-025 Without DECODE_STATS_EN the ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-026 Shared package SHALL hold the format enum, the nine opcode constants and a packed decoded-instruction struct.
REQ-027 Combinational field/immediate extraction SHALL be a sub-module decode_fields; instr_decode holds handshake and buffering.

Verification
REQ-028 0xFFF00093 (ADDI x1,x0,-1) -> opcode 0x13, rd 1, rs1 0, funct3 0, imm 0xFFFFFFFF, fmt I, out_valid one cycle after accept.
REQ-029 0x0020A423 (SW x2,8(x1)) -> fmt S, rs1 1, rs2 2, funct3 2, imm 0x00000008; 0xFFDFF06F (JAL x0,-4) -> fmt J, rd 0, imm 0xFFFFFFFC.
REQ-030 0x00000000 -> fmt ILLEGAL, out_illegal 1, imm 0.
REQ-031 out_ready=0 for 4 cycles while three instructions are offered -> in_ready=0 after second accept, third held upstream; release yields all three in order.
REQ-032 flush while FULL with in_valid=1 -> out_valid=0 next cycle, in_ready=1, offered instruction not emitted.
REQ-033 rst asserted while FULL -> out_valid drops without waiting for clk, all outputs at reset values, stats (if enabled) 0.
